// File: rtl/uart_pkg.sv
// Shared UART types and defaults, common to the transmitter and receiver.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam int UART_TICKS_PER_BIT = 16;
  localparam int UART_DATA_WIDTH    = 8;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the serial line plus a previous-sample flop for
// falling-edge detection. Everything resets to the idle (high) line level.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic rx_in,
  output logic rx_s,
  output logic fall_edge
);

  logic rx_m;
  logic rx_p;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_p <= 1'b1;
    end else begin
      rx_m <= rx_in;
      rx_s <= rx_m;
      rx_p <= rx_s;
    end
  end

  assign fall_edge = rx_p & ~rx_s;

endmodule

// File: rtl/uart_rx.sv
// Oversampled UART receiver: centres on each bit, shifts LSB-first, checks
// the stop bit and pulses rx_done (with frame_err) once per frame.
module uart_rx
  import uart_pkg::*;
#(
  parameter int TICKS_PER_BIT = UART_TICKS_PER_BIT,
  parameter int DATA_WIDTH    = UART_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_in,
  input  logic                  sample_tick,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  rx_done,
  output logic                  frame_err,
  output logic                  baud_en
);

  localparam int TW = $clog2(TICKS_PER_BIT);
  localparam int BW = $clog2(DATA_WIDTH);
  localparam logic [TW-1:0] TICK_HALF = TW'(TICKS_PER_BIT/2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);

  logic rx_s;
  logic fall_edge;

  uart_rx_sync u_sync (
    .clk       (clk),
    .rst       (rst),
    .rx_in     (rx_in),
    .rx_s      (rx_s),
    .fall_edge (fall_edge)
  );

  state_t                state, state_next;
  logic [TW-1:0]         tick_cnt, tick_next;
  logic [BW-1:0]         bit_cnt, bit_next;
  logic [DATA_WIDTH-1:0] sh, sh_next;
  logic [DATA_WIDTH-1:0] dout_next;
  logic                  done_next;
  logic                  ferr_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      sh        <= '0;
      dout      <= '0;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
      baud_en   <= 1'b0;
    end else begin
      state     <= state_next;
      tick_cnt  <= tick_next;
      bit_cnt   <= bit_next;
      sh        <= sh_next;
      dout      <= dout_next;
      rx_done   <= done_next;
      frame_err <= ferr_next;
      baud_en   <= (state_next != IDLE);
    end
  end

  always_comb begin
    state_next = state;
    tick_next  = tick_cnt;
    bit_next   = bit_cnt;
    sh_next    = sh;
    dout_next  = dout;
    done_next  = 1'b0;
    ferr_next  = 1'b0;
    unique case (state)
      // Only a genuine high-to-low transition starts a frame, so a held-low
      // line (break, or after a framing error) cannot retrigger.
      IDLE: begin
        if (fall_edge) begin
          state_next = START;
          tick_next  = '0;
        end
      end
      START: begin
        if (sample_tick) begin
          if (tick_cnt == TICK_HALF) begin
            tick_next = '0;
            if (!rx_s) begin
              state_next = DATA;
              bit_next   = '0;
            end else begin
              state_next = IDLE;
            end
          end else begin
            tick_next = tick_cnt + 1'b1;
          end
        end
      end
      DATA: begin
        if (sample_tick) begin
          if (tick_cnt == TICK_LAST) begin
            sh_next   = {rx_s, sh[DATA_WIDTH-1:1]};
            tick_next = '0;
            if (bit_cnt == BIT_LAST) begin
              state_next = STOP;
            end else begin
              bit_next = bit_cnt + 1'b1;
            end
          end else begin
            tick_next = tick_cnt + 1'b1;
          end
        end
      end
      // Finishing mid stop bit leaves half a bit to catch a back-to-back start.
      STOP: begin
        if (sample_tick) begin
          if (tick_cnt == TICK_LAST) begin
            dout_next  = sh;
            done_next  = 1'b1;
            ferr_next  = ~rx_s;
            state_next = IDLE;
            tick_next  = '0;
          end else begin
            tick_next = tick_cnt + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: 16 ticks/bit, 8 data bits, a tick every 4 clk.
module tb_uart_rx;

  localparam int BIT_CLKS = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_in = 1'b1;
  logic       sample_tick = 1'b0;
  logic [7:0] dout;
  logic       rx_done;
  logic       frame_err;
  logic       baud_en;

  int n_cmp = 0;
  int n_err = 0;

  uart_rx #(.TICKS_PER_BIT(16), .DATA_WIDTH(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_in       (rx_in),
    .sample_tick (sample_tick),
    .dout        (dout),
    .rx_done     (rx_done),
    .frame_err   (frame_err),
    .baud_en     (baud_en)
  );

  always #5 clk = ~clk;

  logic [1:0] div = 2'd0;
  int         cyc = 0;
  always @(posedge clk) begin
    div         <= div + 2'd1;
    sample_tick <= (div == 2'd2);
    cyc         <= cyc + 1;
  end

  int         done_cnt = 0;
  int         ferr_alone = 0;
  logic [7:0] last_dout = 8'h00;
  logic       last_ferr = 1'b0;
  logic       last_be = 1'b0;
  logic       be_prev = 1'b0;
  logic       be_before_done = 1'b0;
  int         done_cyc = 0;
  always @(negedge clk) begin
    be_prev <= baud_en;
    if (rx_done) begin
      done_cnt       <= done_cnt + 1;
      last_dout      <= dout;
      last_ferr      <= frame_err;
      last_be        <= baud_en;
      be_before_done <= be_prev;
      done_cyc       <= cyc;
    end
    if (frame_err && !rx_done) ferr_alone <= ferr_alone + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic b);
    rx_in = b;
    repeat (BIT_CLKS) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(stop);
  endtask

  int base;
  int start_cyc;
  int lat;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_dout", {24'h0, dout}, 32'h00);
    check("reset_done", {31'h0, rx_done}, 32'h0);
    check("reset_ferr", {31'h0, frame_err}, 32'h0);
    check("reset_baud_en", {31'h0, baud_en}, 32'h0);
    repeat (20) @(posedge clk);
    #1;

    // 1: 0x55 with a good stop bit, with exact baud_en rise timing
    base  = done_cnt;
    rx_in = 1'b0;
    repeat (3) @(negedge clk);
    check("t1_baud_en_pre", {31'h0, baud_en}, 32'h0);
    @(negedge clk);
    check("t1_baud_en_rise", {31'h0, baud_en}, 32'h1);
    repeat (BIT_CLKS - 3) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) drive_bit(i[0] ? 1'b0 : 1'b1);
    drive_bit(1'b1);
    check("t1_done_cnt", done_cnt - base, 1);
    check("t1_dout", {24'h0, last_dout}, 32'h55);
    check("t1_ferr", {31'h0, last_ferr}, 32'h0);
    check("t1_baud_en_at_done", {31'h0, last_be}, 32'h0);
    check("t1_baud_en_before_done", {31'h0, be_before_done}, 32'h1);

    // 2: start glitch of 4 ticks
    base  = done_cnt;
    rx_in = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check("t2_baud_en_active", {31'h0, baud_en}, 32'h1);
    repeat (4) @(posedge clk);
    #1;
    rx_in = 1'b1;
    repeat (2 * BIT_CLKS) @(posedge clk);
    #1;
    check("t2_baud_en_dropped", {31'h0, baud_en}, 32'h0);
    check("t2_no_done", done_cnt - base, 0);
    check("t2_dout_held", {24'h0, dout}, 32'h55);

    // 3: framing error, held-low line, then a clean frame
    base = done_cnt;
    send_frame(8'hA3, 1'b0);
    for (int i = 0; i < 3; i++) drive_bit(1'b0);
    check("t3_one_done", done_cnt - base, 1);
    check("t3_dout", {24'h0, last_dout}, 32'hA3);
    check("t3_ferr", {31'h0, last_ferr}, 32'h1);
    check("t3_idle_while_low", {31'h0, baud_en}, 32'h0);
    drive_bit(1'b1);
    send_frame(8'h01, 1'b1);
    check("t3_second_done", done_cnt - base, 2);
    check("t3_dout2", {24'h0, last_dout}, 32'h01);
    check("t3_ferr2", {31'h0, last_ferr}, 32'h0);

    // 4: back-to-back frames with no idle gap
    base = done_cnt;
    send_frame(8'h00, 1'b1);
    check("t4_dout_a", {24'h0, last_dout}, 32'h00);
    check("t4_ferr_a", {31'h0, last_ferr}, 32'h0);
    send_frame(8'hFF, 1'b1);
    check("t4_done_cnt", done_cnt - base, 2);
    check("t4_dout_b", {24'h0, last_dout}, 32'hFF);
    check("t4_ferr_b", {31'h0, last_ferr}, 32'h0);

    // 5: reset during the 4th data bit of 0x3C, then a clean 0x96
    base = done_cnt;
    drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b1);
    rx_in = 1'b1;
    repeat (32) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("t5_dout_reset", {24'h0, dout}, 32'h00);
    check("t5_baud_en_reset", {31'h0, baud_en}, 32'h0);
    drive_bit(1'b1);
    drive_bit(1'b1);
    check("t5_no_done_aborted", done_cnt - base, 0);
    send_frame(8'h96, 1'b1);
    check("t5_done_cnt", done_cnt - base, 1);
    check("t5_dout", {24'h0, last_dout}, 32'h96);

    // 6: 0x3C from a transmitter-timed serializer; done lands mid stop bit
    base      = done_cnt;
    start_cyc = cyc;
    send_frame(8'h3C, 1'b1);
    lat = done_cyc - start_cyc;
    check("t6_done_cnt", done_cnt - base, 1);
    check("t6_dout", {24'h0, last_dout}, 32'h3C);
    check("t6_done_mid_stop", {31'h0, (lat >= 600 && lat <= 630)}, 32'h1);

    check("no_lone_frame_err", ferr_alone, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
